// File: rtl/alu_operand_stage.sv
// alu_operand_stage: forwarding, load-use hazard detection and registered ALU operand select behind a valid/ready handshake
// Ports: clk/rst_n; decode side in_valid/in_ready, alu_src, sign_ext, rs/rt with rs_data/rt_data, imm16, shamt;
// forwarding fwd_ex_*/fwd_mem_*; load hazard ex_load_pending/ex_load_reg; flush; ALU side out_valid/out_ready,
// op_a/op_b, illegal; stall_count saturating hazard-stall counter.
module alu_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_src,
  input  logic               sign_ext,
  input  logic [4:0]         rs,
  input  logic [4:0]         rt,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  input  logic [15:0]        imm16,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               fwd_ex_wr,
  input  logic               fwd_mem_wr,
  input  logic [4:0]         fwd_ex_reg,
  input  logic [4:0]         fwd_mem_reg,
  input  logic [WIDTH-1:0]   fwd_ex_data,
  input  logic [WIDTH-1:0]   fwd_mem_data,
  input  logic               ex_load_pending,
  input  logic [4:0]         ex_load_reg,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               illegal,
  output logic [CNT_W-1:0]   stall_count
);
  logic [WIDTH-1:0] fa, fb, sx16, sel_a, sel_b;
  logic use_rs, use_rt, hazard, accept, sel_ill;
  always_comb begin
    fa = (rs != 5'd0 && fwd_ex_wr && fwd_ex_reg == rs) ? fwd_ex_data :
         (rs != 5'd0 && fwd_mem_wr && fwd_mem_reg == rs) ? fwd_mem_data : rs_data;
    fb = (rt != 5'd0 && fwd_ex_wr && fwd_ex_reg == rt) ? fwd_ex_data :
         (rt != 5'd0 && fwd_mem_wr && fwd_mem_reg == rt) ? fwd_mem_data : rt_data;
    use_rs = alu_src == 3'd0 || alu_src == 3'd1 || alu_src == 3'd4;
    use_rt = alu_src == 3'd0 || alu_src == 3'd3 || alu_src == 3'd4;
    hazard = ex_load_pending && ex_load_reg != 5'd0 &&
             ((use_rs && ex_load_reg == rs) || (use_rt && ex_load_reg == rt));
    in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready);
    accept = in_valid && in_ready;
    sx16 = {{(WIDTH-16){imm16[15]}}, imm16};
    sel_ill = alu_src > 3'd4;
    sel_a = (alu_src == 3'd0 || alu_src == 3'd1) ? fa :
            (alu_src == 3'd3 || alu_src == 3'd4) ? fb : '0;
    sel_b = alu_src == 3'd0 ? fb :
            alu_src == 3'd1 ? (sign_ext ? sx16 : WIDTH'(imm16)) :
            alu_src == 3'd2 ? sx16 << 16 :
            alu_src == 3'd3 ? WIDTH'(shamt) :
            alu_src == 3'd4 ? WIDTH'(fa[SHAMT_W-1:0]) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      illegal     <= 1'b0;
      stall_count <= '0;
    end else begin
      if (flush) out_valid <= 1'b0;
      else if (accept) begin
        out_valid <= 1'b1;
        op_a      <= sel_a;
        op_b      <= sel_b;
        illegal   <= sel_ill;
      end else if (out_ready) out_valid <= 1'b0;
      if (in_valid && hazard && !flush && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed self-checking bench for alu_operand_stage (CNT_W=2 to reach saturation)
module tb_alu_operand_stage;
  logic clk = 0, rst_n = 0;
  logic in_valid, in_ready, sign_ext, fwd_ex_wr, fwd_mem_wr, ex_load_pending, flush;
  logic out_valid, out_ready, illegal;
  logic [2:0] alu_src;
  logic [4:0] rs, rt, fwd_ex_reg, fwd_mem_reg, ex_load_reg;
  logic [31:0] rs_data, rt_data, fwd_ex_data, fwd_mem_data, op_a, op_b;
  logic [15:0] imm16;
  logic [4:0] shamt;
  logic [1:0] stall_count;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(32), .SHAMT_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .alu_src(alu_src),
    .sign_ext(sign_ext), .rs(rs), .rt(rt), .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
    .shamt(shamt), .fwd_ex_wr(fwd_ex_wr), .fwd_mem_wr(fwd_mem_wr), .fwd_ex_reg(fwd_ex_reg),
    .fwd_mem_reg(fwd_mem_reg), .fwd_ex_data(fwd_ex_data), .fwd_mem_data(fwd_mem_data),
    .ex_load_pending(ex_load_pending), .ex_load_reg(ex_load_reg), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b), .illegal(illegal),
    .stall_count(stall_count)
  );

  logic [2:0]  m_tab  [7] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
  logic        sx_tab [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] a_tab  [7] = '{32'h10, 32'h10, 32'h10, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0};
  logic [31:0] b_tab  [7] = '{32'hFFFF_FFF0, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000, 32'h3, 32'h10, 32'h0};
  logic        i_tab  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic idle();
    in_valid = 0; alu_src = 0; sign_ext = 0; rs = 1; rt = 2;
    rs_data = 32'h10; rt_data = 32'hFFFF_FFF0; imm16 = 16'h8001; shamt = 3;
    fwd_ex_wr = 0; fwd_mem_wr = 0; fwd_ex_reg = 0; fwd_mem_reg = 0;
    fwd_ex_data = 0; fwd_mem_data = 0; ex_load_pending = 0; ex_load_reg = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    in_valid = 1;
    rst_n = 0;
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if ({op_a, op_b} !== 64'h0) begin errors++; $display("FAIL reset_ops: got %h/%h expected 0/0", op_a, op_b); end
    checks++; if ({illegal, stall_count} !== 3'b0) begin errors++; $display("FAIL reset_ill_cnt: got %b/%0d expected 0/0", illegal, stall_count); end
    rst_n = 1;
    in_valid = 0;
    tick();
  endtask

  task automatic test_modes();
    for (int i = 0; i < 7; i++) begin
      idle();
      in_valid = 1; alu_src = m_tab[i]; sign_ext = sx_tab[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || op_a !== a_tab[i] || op_b !== b_tab[i] || illegal !== i_tab[i]) begin
        errors++;
        $display("FAIL mode_%0d: got v=%b a=%h b=%h ill=%b expected v=1 a=%h b=%h ill=%b",
                 m_tab[i], out_valid, op_a, op_b, illegal, a_tab[i], b_tab[i], i_tab[i]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_forward();
    idle();
    in_valid = 1; rs = 5; rt = 6;
    fwd_ex_wr = 1; fwd_ex_reg = 5; fwd_ex_data = 32'hAAAA;
    fwd_mem_wr = 1; fwd_mem_reg = 5; fwd_mem_data = 32'hBBBB;
    tick();
    checks++; if (op_a !== 32'hAAAA) begin errors++; $display("FAIL fwd_ex_priority: got %h expected 0000aaaa", op_a); end
    checks++; if (op_b !== 32'hFFFF_FFF0) begin errors++; $display("FAIL fwd_rt_regfile: got %h expected fffffff0", op_b); end
    fwd_ex_wr = 0;
    tick();
    checks++; if (op_a !== 32'hBBBB) begin errors++; $display("FAIL fwd_mem: got %h expected 0000bbbb", op_a); end
    fwd_ex_wr = 1; rs = 0;
    tick();
    checks++; if (op_a !== 32'h10) begin errors++; $display("FAIL fwd_r0_rs0: got %h expected 00000010", op_a); end
    fwd_ex_reg = 0; fwd_mem_reg = 0;
    tick();
    checks++; if (op_a !== 32'h10) begin errors++; $display("FAIL fwd_r0_reg0: got %h expected 00000010", op_a); end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    do_reset();
    in_valid = 1; rt = 7; ex_load_pending = 1; ex_load_reg = 7;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall1: got %b expected 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL lu_stall2: got rdy=%b v=%b expected 0/0", in_ready, out_valid); end
    tick();
    checks++; if (stall_count !== 2'd2) begin errors++; $display("FAIL lu_count: got %0d expected 2", stall_count); end
    ex_load_pending = 0; fwd_ex_wr = 1; fwd_ex_reg = 7; fwd_ex_data = 32'h1234;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_clear_ready: got %b expected 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || op_b !== 32'h1234) begin errors++; $display("FAIL lu_accept: got v=%b b=%h expected 1/00001234", out_valid, op_b); end
    fwd_ex_wr = 0; alu_src = 3'd1; ex_load_pending = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_unused_rt: got %b expected 1", in_ready); end
    tick();
    checks++; if (stall_count !== 2'd2) begin errors++; $display("FAIL lu_unused_count: got %0d expected 2", stall_count); end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    tick();
    in_valid = 1; rs_data = 32'h1;
    tick();
    checks++; if (out_valid !== 1'b1 || op_a !== 32'h1) begin errors++; $display("FAIL bp_op1: got v=%b a=%h expected 1/00000001", out_valid, op_a); end
    rs_data = 32'h2; out_ready = 0;
    for (int c = 2; c <= 4; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d: got %b expected 0", c, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || op_a !== 32'h1 || op_b !== 32'hFFFF_FFF0) begin errors++; $display("FAIL bp_hold_c%0d: got v=%b a=%h b=%h expected 1/00000001/fffffff0", c, out_valid, op_a, op_b); end
    end
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b1 || op_a !== 32'h2) begin errors++; $display("FAIL bp_op2: got v=%b a=%h expected 1/00000002", out_valid, op_a); end
    rs_data = 32'h3;
    tick();
    checks++; if (out_valid !== 1'b1 || op_a !== 32'h3) begin errors++; $display("FAIL bp_op3: got v=%b a=%h expected 1/00000003", out_valid, op_a); end
    in_valid = 0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    idle();
    in_valid = 1; rs_data = 32'h55;
    tick();
    flush = 1; rs_data = 32'h66;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || op_a !== 32'h55) begin errors++; $display("FAIL flush_drop: got v=%b a=%h expected 0/00000055", out_valid, op_a); end
    idle();
    tick();
  endtask

  task automatic test_saturate_async_reset();
    idle();
    do_reset();
    in_valid = 1; rs = 9; ex_load_pending = 1; ex_load_reg = 9;
    repeat (5) tick();
    checks++; if (stall_count !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d expected 3", stall_count); end
    ex_load_pending = 0; rs_data = 32'hDEAD_BEEF;
    tick();
    checks++; if (out_valid !== 1'b1 || op_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ar_pre: got v=%b a=%h expected 1/deadbeef", out_valid, op_a); end
    #2;
    rst_n = 0;
    #1;
    checks++; if ({out_valid, illegal, in_ready} !== 3'b0 || {op_a, op_b} !== 64'h0 || stall_count !== 2'd0) begin
      errors++;
      $display("FAIL ar_async: got v=%b ill=%b rdy=%b a=%h b=%h cnt=%0d expected all 0", out_valid, illegal, in_ready, op_a, op_b, stall_count);
    end
    in_valid = 0;
    tick();
    rst_n = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_no_pulse: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_forward();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_saturate_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised operand-select and EX-entry pipeline register for the MIPS datapath. Takes decoded register-file reads, the raw 16-bit immediate and the shift amount, resolves EX/MEM and MEM/WB forwarding, detects load-use hazards, and registers the two ALU operands behind a valid/ready handshake. It replaces the purely combinational operand mux. It adds LUI and variable-shift modes, a defined illegal-mode response, flush, and a stall counter.

## Interface
- WIDTH, 32: datapath width; must be ≥ 32.
- SHAMT_W, 5: shift-amount width; must be < WIDTH.
- CNT_W, 16: stall counter width.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- alu_src  in  3  mode: 000 R, 001 I, 010 LUI, 011 shift-imm, 100 shift-var, others illegal
- sign_ext  in  1  1 = sign-extend imm16 in mode I, 0 = zero-extend
- rs, rt  in  5 each  source register numbers
- rs_data, rt_data  in  WIDTH each  register-file read data
- imm16  in  16  raw immediate
- shamt  in  SHAMT_W  instruction shift amount
- fwd_ex_wr, fwd_mem_wr  in  1 each  producer in EX/MEM, MEM/WB will write a register
- fwd_ex_reg, fwd_mem_reg  in  5 each  destination register
- fwd_ex_data, fwd_mem_data  in  WIDTH each  forwarded result
- ex_load_pending  in  1  load in EX whose data is not yet available
- ex_load_reg  in  5  destination of that load
- flush  in  1  discard the registered operation
- out_valid  out  1  operands valid for ALU
- out_ready  in  1  ALU consumes
- op_a, op_b  out  WIDTH each  registered ALU operands
- illegal  out  1  registered: captured alu_src was illegal
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Forwarding: for each of rs and rt, the value is taken from the highest-priority matching source. EX/MEM has the highest priority, then MEM/WB, then register-file data. A source matches when its wr bit is 1 and its reg equals the source register. Register 0 never forwards and always reads rs_data/rt_data as given.
- Used registers per mode: R uses rs, rt. I uses rs. LUI uses none. shift-imm uses rt. shift-var uses rs, rt.
- Hazard: asserted when ex_load_pending=1, ex_load_reg≠0, and ex_load_reg equals a used register. It does not fire on unused registers.
- Operand select, using forwarded values fa (rs) and fb (rt):
  - R: a=fa, b=fb.
  - I: a=fa, b=ext(imm16), sign- or zero-extended to WIDTH per sign_ext.
  - LUI: a=0, b={imm16,16'h0} sign-extended from bit 31 to WIDTH.
  - shift-imm: a=fb, b=zero-extended shamt.
  - shift-var: a=fb, b=zero-extended fa[SHAMT_W-1:0].
  - illegal: a=0, b=0, illegal=1.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept: when in_valid && in_ready, at the edge op_a/op_b/illegal load the selected values and out_valid becomes 1.
- Drain: when out_valid && out_ready with no accept, out_valid becomes 0.
- Flush: at the edge out_valid becomes 0. No accept occurs that cycle. Flush wins over out_ready and in_valid.
- stall_count increments by 1 on each cycle with in_valid && hazard && !flush. It holds at 2^CNT_W−1 and clears only on reset.
- While out_valid=1 and out_ready=0, op_a, op_b and illegal hold stable.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, op_a=0, op_b=0, illegal=0, stall_count=0. in_ready is 0 during reset.
- Latency: 1 cycle, from accept edge to out_valid.
- Throughput: 1 op per cycle when out_ready=1 and there is no hazard. in_ready depends combinationally on out_ready, flush and the hazard inputs.
- Forwarding and hazard inputs are sampled in the cycle of acceptance only.
- A stalled op is re-evaluated each cycle. It is accepted in the first cycle the hazard clears, with the forwarding values of that cycle.
- Reset asserted mid-transfer drops the held op without an output pulse.

## Test plan
- Mode sweep, no forwarding: rs_data=0x0000_0010, rt_data=0xFFFF_FFF0, imm16=0x8001, shamt=3.
  - R -> a=0x10, b=0xFFFFFFF0.
  - I with sign_ext=1 -> b=0xFFFF8001; with sign_ext=0 -> b=0x00008001.
  - LUI -> a=0, b=0x80010000.
  - shift-imm -> a=0xFFFFFFF0, b=3.
  - shift-var -> b=0x10.
  - mode 111 -> a=0, b=0, illegal=1.
- Forward priority: rs=5, both fwd_ex and fwd_mem writing reg 5 with data 0xAAAA and 0xBBBB -> a=0xAAAA. With rs=0 under the same stimulus -> a=rs_data.
- Load-use: mode R, rt=7, ex_load_pending=1, ex_load_reg=7, held for 2 cycles -> in_ready=0 for 2 cycles and stall_count=2. Then accept with fwd_ex data. In mode I with the same rt there is no stall.
- Backpressure: 3 back-to-back ops with out_ready=0 on cycles 2–4 -> op_a/op_b hold stable, in_ready=0, and no op is lost or duplicated.
- Flush with out_valid=1, out_ready=1 and in_valid=1 -> next cycle out_valid=0 and the input is not accepted.
- Async reset mid-stream, plus CNT_W=2 saturation: after 5 hazard cycles stall_count=3. rst_n low with no clock edge -> all outputs 0 immediately.
